vgpr_rd_port_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the shared VGPR read port. Up to 8 requesters (ALU/LSU operand fetch lanes) raise level requests with a 10-bit VGPR row address; the block grants at most one per cycle, drives the registered one-hot enable and address set feeding the 8-to-1 read-port mux, and returns a one-hot data-valid strobe to the granted requester once the bank read latency has elapsed. It sits between the requesters and the read-port mux/bank pair.

---
 rtl/vgpr_rd_port_arbiter.sv | 103 ++++++++++
 tb/tb_vgpr_rd_port_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vgpr_rd_port_arbiter.sv
// vgpr_rd_port_arbiter: round-robin arbiter/sequencer for the shared VGPR read port.
// Macro VGPR_RD_ARB_PORT0_PRIO_EN gives requester 0 absolute priority.
module vgpr_rd_port_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int RD_LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          req,
  input  logic [8*ADDR_W-1:0] req_addr,
  input  logic                bank_busy,
  output logic [7:0]          gnt,
  output logic [7:0]          port_rd_en,
  output logic [8*ADDR_W-1:0] port_rd_addr,
  output logic [7:0]          rd_data_vld
);

  logic [2:0] ptr;
  logic [2:0] gnt_idx;
  logic       gnt_any;
  logic [2:0] idx;
  logic       ptr_upd;
  logic [7:0] vld_pipe [RD_LATENCY];
`ifdef VGPR_RD_ARB_PORT0_PRIO_EN
  logic [2:0] start;
  logic [3:0] sum;
`endif

  // Grant the first pending requester at or after ptr (comb, no req feedback).
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = '0;
`ifdef VGPR_RD_ARB_PORT0_PRIO_EN
    start   = (ptr == 3'd0) ? 3'd1 : ptr;
    sum     = '0;
    if (rst_n && !bank_busy && |req) begin
      if (req[0]) begin
        gnt_any = 1'b1;
      end else begin
        for (int k = 0; k < 7; k++) begin
          sum = {1'b0, start} + 4'(k);
          idx = (sum > 4'd7) ? 3'(sum - 4'd7) : sum[2:0];
          if (!gnt_any && req[idx]) begin
            gnt_any = 1'b1;
            gnt_idx = idx;
          end
        end
      end
    end
`else
    if (rst_n && !bank_busy && |req) begin
      for (int k = 0; k < 8; k++) begin
        idx = ptr + 3'(k);
        if (!gnt_any && req[idx]) begin
          gnt_any = 1'b1;
          gnt_idx = idx;
        end
      end
    end
`endif
    if (gnt_any) gnt = 8'b1 << gnt_idx;
  end

  // Port 0 under absolute priority leaves the round-robin pointer alone.
  always_comb begin
`ifdef VGPR_RD_ARB_PORT0_PRIO_EN
    ptr_upd = gnt_any && (gnt_idx != 3'd0);
`else
    ptr_upd = gnt_any;
`endif
  end

  // Pointer advance and registered enable/address toward the mux.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr          <= '0;
      port_rd_en   <= '0;
      port_rd_addr <= '0;
    end else begin
      if (ptr_upd) ptr <= gnt_idx + 3'd1;
      port_rd_en <= gnt;
      for (int i = 0; i < 8; i++) begin
        port_rd_addr[i*ADDR_W +: ADDR_W] <=
          gnt[i] ? req_addr[i*ADDR_W +: ADDR_W] : '0;
      end
    end
  end

  // Fixed-latency valid pipeline; runs regardless of bank_busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LATENCY; i++) vld_pipe[i] <= '0;
    end else begin
      vld_pipe[0] <= port_rd_en;
      for (int i = 1; i < RD_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  assign rd_data_vld = vld_pipe[RD_LATENCY-1];

endmodule

// File: tb/tb_vgpr_rd_port_arbiter.sv
// tb_vgpr_rd_port_arbiter: directed and randomized checks of the VGPR read-port arbiter.
// Honors VGPR_RD_ARB_PORT0_PRIO_EN the same way the design does.
module tb_vgpr_rd_port_arbiter;
  localparam int AW  = 10;
  localparam int LAT = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    req;
  logic [8*AW-1:0] req_addr;
  logic          bank_busy;
  logic [7:0]    gnt;
  logic [7:0]    port_rd_en;
  logic [8*AW-1:0] port_rd_addr;
  logic [7:0]    rd_data_vld;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  vgpr_rd_port_arbiter #(.ADDR_W(AW), .RD_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr),
    .bank_busy(bank_busy), .gnt(gnt), .port_rd_en(port_rd_en),
    .port_rd_addr(port_rd_addr), .rd_data_vld(rd_data_vld)
  );

  task automatic do_reset();
    rst_n = 1'b0; req = '0; req_addr = '0; bank_busy = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++;
    if ({gnt, port_rd_en, rd_data_vld} !== 24'h0 || port_rd_addr !== '0) begin
      n_bad++;
      $display("FAIL reset_state: gnt=%h en=%h vld=%h addr=%h, want all 0",
               gnt, port_rd_en, rd_data_vld, port_rd_addr);
    end
    @(negedge clk);
    req = 8'hFF;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({gnt, port_rd_en, rd_data_vld} !== 24'h0 || port_rd_addr !== '0) begin
      n_bad++;
      $display("FAIL reset_midstream: gnt=%h en=%h vld=%h addr=%h, want all 0",
               gnt, port_rd_en, rd_data_vld, port_rd_addr);
    end
    @(negedge clk);
    req = '0;
    rst_n = 1'b1;
    for (int c = 0; c < LAT + 2; c++) begin
      #1;
      n_cmp++;
      if (rd_data_vld !== 8'h00) begin
        n_bad++;
        $display("FAIL reset_no_strobe: vld=%h want 00 cycle %0d", rd_data_vld, c);
      end
      @(negedge clk);
    end
    req = 8'hFF;
    #1;
    n_cmp++;
    if (gnt !== 8'h01) begin
      n_bad++;
      $display("FAIL reset_first_grant: gnt=%h want 01", gnt);
    end
    @(negedge clk);
    req = '0;
  endtask

  task automatic test_single();
    do_reset();
    req = 8'h04;
    req_addr[2*AW +: AW] = 10'h155;
    #1;
    n_cmp++;
    if (gnt !== 8'h04 || port_rd_en !== 8'h00) begin
      n_bad++;
      $display("FAIL single_gnt: gnt=%h en=%h want 04/00", gnt, port_rd_en);
    end
    @(negedge clk);
    req = '0;
    #1;
    n_cmp++;
    if (port_rd_en !== 8'h04 || port_rd_addr !== (80'h155 << (2*AW))) begin
      n_bad++;
      $display("FAIL single_issue: en=%h addr=%h want 04 lane2=155", port_rd_en, port_rd_addr);
    end
    repeat (LAT) @(negedge clk);
    #1;
    n_cmp++;
    if (rd_data_vld !== 8'h04 || port_rd_en !== 8'h00) begin
      n_bad++;
      $display("FAIL single_vld: vld=%h en=%h want 04/00", rd_data_vld, port_rd_en);
    end
  endtask

`ifndef VGPR_RD_ARB_PORT0_PRIO_EN
  task automatic test_fairness();
    int cnt [8];
    do_reset();
    for (int i = 0; i < 8; i++) cnt[i] = 0;
    req = 8'hFF;
    for (int c = 0; c < 16; c++) begin
      #1;
      n_cmp++;
      if (gnt !== 8'(1 << (c % 8)) || !$onehot0(port_rd_en)) begin
        n_bad++;
        $display("FAIL fair_order: cycle %0d gnt=%h en=%h want gnt=%h",
                 c, gnt, port_rd_en, 8'(1 << (c % 8)));
      end
      for (int i = 0; i < 8; i++) if (gnt[i]) cnt[i]++;
      @(negedge clk);
    end
    req = '0;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (cnt[i] != 2) begin
        n_bad++;
        $display("FAIL fair_count: port %0d granted %0d want 2", i, cnt[i]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp [3];
    exp[0] = 8'h80; exp[1] = 8'h01; exp[2] = 8'h80;
    do_reset();
    req = 8'h20;
    @(negedge clk);
    req = 8'h81;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++;
      if (gnt !== exp[c]) begin
        n_bad++;
        $display("FAIL wrap: step %0d gnt=%h want %h", c, gnt, exp[c]);
      end
      @(negedge clk);
    end
    req = '0;
  endtask
`else
  task automatic test_prio();
    do_reset();
    req = 8'h03;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_cmp++;
      if (gnt !== 8'h01) begin
        n_bad++;
        $display("FAIL prio_port0: step %0d gnt=%h want 01", c, gnt);
      end
      @(negedge clk);
    end
    req = 8'h06;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_cmp++;
      if (gnt !== ((c % 2 == 0) ? 8'h02 : 8'h04)) begin
        n_bad++;
        $display("FAIL prio_rr: step %0d gnt=%h want %h",
                 c, gnt, (c % 2 == 0) ? 8'h02 : 8'h04);
      end
      @(negedge clk);
    end
    req = '0;
  endtask
`endif

  task automatic test_busy();
    do_reset();
    req = 8'h02;
    @(negedge clk);
    req = 8'h12;
    bank_busy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++;
      if (gnt !== 8'h00 || port_rd_en !== ((c == 0) ? 8'h02 : 8'h00) ||
          rd_data_vld !== ((c == LAT) ? 8'h02 : 8'h00)) begin
        n_bad++;
        $display("FAIL busy_hold: cycle %0d gnt=%h en=%h vld=%h", c, gnt, port_rd_en, rd_data_vld);
      end
      @(negedge clk);
    end
    bank_busy = 1'b0;
    #1;
    n_cmp++;
    if (gnt !== 8'h10) begin
      n_bad++;
      $display("FAIL busy_release: gnt=%h want 10", gnt);
    end
    @(negedge clk);
    req = '0;
  endtask

  task automatic test_random();
    int mptr;
    int g;
    int s;
    logic [7:0] men;
    logic [7:0] eg;
    logic [8*AW-1:0] maddr;
    logic [7:0] vq [$];
    do_reset();
    mptr = 0; men = '0; maddr = '0; g = -1;
    vq = {};
    repeat (LAT) vq.push_back(8'h00);
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 8; i++) begin
        if (i == g) begin
          if ($urandom % 2 == 0) req[i] = 1'b0;
          else req_addr[i*AW +: AW] = AW'($urandom);
        end else if (!req[i] && ($urandom % 3 == 0)) begin
          req[i] = 1'b1;
          req_addr[i*AW +: AW] = AW'($urandom);
        end
      end
      bank_busy = ($urandom % 4 == 0);
      g = -1;
      if (!bank_busy && req != 8'h00) begin
`ifdef VGPR_RD_ARB_PORT0_PRIO_EN
        if (req[0]) g = 0;
        else begin
          s = (mptr == 0) ? 1 : mptr;
          for (int o = 0; o < 7; o++)
            if (g < 0 && req[(s - 1 + o) % 7 + 1]) g = (s - 1 + o) % 7 + 1;
        end
`else
        for (int o = 0; o < 8; o++)
          if (g < 0 && req[(mptr + o) % 8]) g = (mptr + o) % 8;
`endif
      end
      eg = (g < 0) ? 8'h00 : 8'(1 << g);
      #1;
      n_cmp++;
      if (gnt !== eg || port_rd_en !== men || port_rd_addr !== maddr ||
          rd_data_vld !== vq[$] || !$onehot0(port_rd_en)) begin
        n_bad++;
        $display("FAIL random: cycle %0d gnt=%h/%h en=%h/%h vld=%h/%h addr=%h/%h (got/want)",
                 c, gnt, eg, port_rd_en, men, rd_data_vld, vq[$], port_rd_addr, maddr);
      end
      vq.push_front(men);
      void'(vq.pop_back());
      men = eg;
      maddr = '0;
      if (g >= 0) begin
        maddr[g*AW +: AW] = req_addr[g*AW +: AW];
`ifdef VGPR_RD_ARB_PORT0_PRIO_EN
        if (g != 0) mptr = (g + 1) % 8;
`else
        mptr = (g + 1) % 8;
`endif
      end
      @(negedge clk);
    end
    req = '0;
    bank_busy = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
`ifndef VGPR_RD_ARB_PORT0_PRIO_EN
    test_fairness();
    test_wrap();
`else
    test_prio();
`endif
    test_busy();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
